// File: rtl/iir_pkg.sv
// Shared filter/datapath package: MAC FSM state, saturation helper, coefficient types.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package iir_pkg;

  // Sequencing states of the iterative multiply-accumulate block.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } mac_state_t;

  // Filter coefficient types shared with the biquad sections.
  localparam int COEF_W = 16;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t b0;
    coef_t b1;
    coef_t b2;
    coef_t a1;
    coef_t a2;
  } biquad_coef_t;

  // Clamp a signed value into the two's-complement range of 'width' bits.
  // Result is returned at 64 bits so callers can both slice it and compare
  // it against the unclamped value to detect that clamping happened.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)
      saturate = hi;
    else if (value < lo)
      saturate = lo;
    else
      saturate = value;
  endfunction

endpackage

// File: rtl/mac_dot_if.sv
// Term/result handshake bundle for mac_dot.
// Latency: n/a (wires only).
// Backpressure: in_ready stalls the term source, out_ready stalls the result.
// Ports: A/B operands, first/last framing, in_valid/in_ready term handshake,
//        OUT/ovf result, out_valid/out_ready result handshake.
interface mac_dot_if #(
  parameter int OPSIZE  = 8,
  parameter int OUTSIZE = 16
);
  logic signed [OPSIZE-1:0]  A;
  logic signed [OPSIZE-1:0]  B;
  logic                      first;
  logic                      last;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [OUTSIZE-1:0] OUT;
  logic                      ovf;
  logic                      out_valid;
  logic                      out_ready;

  // Term source / result sink side.
  modport master (
    output A, B, first, last, in_valid, out_ready,
    input  in_ready, OUT, ovf, out_valid
  );

  // MAC side.
  modport slave (
    input  A, B, first, last, in_valid, out_ready,
    output in_ready, OUT, ovf, out_valid
  );
endinterface

// File: rtl/mac_dot_mul.sv
// Signed iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: N cycles from the start edge; done is high during the last step cycle.
// Backpressure: none; a start while busy restarts with the new operands.
// Ports: clk, reset_n, start (loads a/b), a/b signed operands,
//        done (final step this cycle), prod (exact signed 2N-bit product).
module mul_seq #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic                  done,
  output logic signed [2*N-1:0] prod
);
  localparam int CW = $clog2(N) + 1;

  logic signed [2*N-1:0] mcand;
  logic        [N-1:0]   mplier;
  logic        [CW-1:0]  cnt;
  logic                  busy;
  logic                  last_step;

  assign last_step = (cnt == CW'(N - 1));
  assign done      = busy && last_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      prod   <= '0;
    end else if (start) begin
      mcand  <= (2*N)'(a);
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
      prod   <= '0;
    end else if (busy) begin
      // The multiplier MSB carries weight -2^(N-1), so that partial
      // product is subtracted instead of added.
      if (mplier[0])
        prod <= last_step ? (prod - mcand) : (prod + mcand);
      mcand  <= {mcand[2*N-2:0], 1'b0};
      mplier <= {1'b0, mplier[N-1:1]};
      cnt    <= cnt + CW'(1);
      if (last_step)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_dot.sv
// Signed dot-product MAC: one term per OPSIZE+2 cycles, scaled and saturated result.
// Latency: result valid OPSIZE+2 cycles after the last term is accepted.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
// Ports: clk, reset_n (async, active-low), bus (mac_dot_if.slave):
//        A/B/first/last/in_valid -> in_ready, OUT/ovf/out_valid <- out_ready.
module mac_dot
  import iir_pkg::*;
#(
  parameter int OPSIZE  = 8,
  parameter int GUARD   = 4,
  parameter int OUTSIZE = 16,
  parameter int SHIFT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  mac_dot_if.slave    bus
);
  localparam int PW   = 2 * OPSIZE;
  localparam int ACCW = 2 * OPSIZE + GUARD;

  mac_state_t state_q, state_d;

  logic                      armed;
  logic                      accept;
  logic                      first_q;
  logic                      last_q;
  logic                      mul_done;
  logic signed [PW-1:0]      prod;
  logic signed [ACCW-1:0]    acc;
  logic signed [ACCW-1:0]    prod_ext;
  logic signed [ACCW-1:0]    sum;
  logic signed [ACCW-1:0]    acc_nxt;
  logic signed [ACCW-1:0]    shifted;
  logic signed [63:0]        sat64;
  logic signed [OUTSIZE-1:0] out_q;
  logic                      ovf_q;
  logic                      add_ovf;
  logic                      clamp;

  mul_seq #(.N(OPSIZE)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .prod    (prod)
  );

  assign accept = bus.in_valid && bus.in_ready;

  // Accumulate datapath, evaluated every cycle but only committed in ACC.
  always_comb begin
    prod_ext = ACCW'(prod);
    sum      = acc + prod_ext;
    // Signed wrap: operands agree in sign but the sum does not.
    add_ovf  = (acc[ACCW-1] == prod_ext[ACCW-1]) && (sum[ACCW-1] != acc[ACCW-1]);
    acc_nxt  = first_q ? prod_ext : sum;
    shifted  = acc_nxt >>> SHIFT;
    sat64    = saturate(64'(shifted), OUTSIZE);
    clamp    = (sat64 != 64'(shifted));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // armed keeps the first edge after reset release from taking a term.
        bus.in_ready = armed;
        if (bus.in_valid && armed)
          state_d = MUL;
      end
      MUL: begin
        if (mul_done)
          state_d = ACC;
      end
      ACC: begin
        state_d = last_q ? HOLD : IDLE;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      armed   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      acc     <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
      if (accept) begin
        first_q <= bus.first;
        last_q  <= bus.last;
        if (bus.first)
          ovf_q <= 1'b0;
      end
      if (state_q == ACC) begin
        acc <= acc_nxt;
        // Clamping only matters for the published result, so it is judged
        // on the closing term; wraps are caught on every term.
        ovf_q <= ovf_q | (!first_q && add_ovf) | (last_q && clamp);
        if (last_q)
          out_q <= sat64[OUTSIZE-1:0];
      end
    end
  end

  assign bus.OUT = out_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_mac_dot.sv
module tb_mac_dot;
  localparam int OPSIZE  = 8;
  localparam int GUARD   = 4;
  localparam int OUTSIZE = 16;
  localparam int ACCW    = 2 * OPSIZE + GUARD;
  localparam longint ACC_MAX = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;
  localparam longint OUT_MAX = (longint'(1) <<< (OUTSIZE - 1)) - 1;
  localparam longint OUT_MIN = -OUT_MAX - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [OPSIZE-1:0] a_d = '0;
  logic signed [OPSIZE-1:0] b_d = '0;
  logic first_d = 1'b0;
  logic last_d = 1'b0;
  logic in_valid_d = 1'b0;
  logic out_ready_d = 1'b0;

  always #5 clk = ~clk;

  // Two DUTs driven in lockstep: SHIFT=0 and SHIFT=4.
  mac_dot_if #(.OPSIZE(OPSIZE), .OUTSIZE(OUTSIZE)) i0 ();
  mac_dot_if #(.OPSIZE(OPSIZE), .OUTSIZE(OUTSIZE)) i1 ();

  assign i0.A = a_d;
  assign i0.B = b_d;
  assign i0.first = first_d;
  assign i0.last = last_d;
  assign i0.in_valid = in_valid_d;
  assign i0.out_ready = out_ready_d;
  assign i1.A = a_d;
  assign i1.B = b_d;
  assign i1.first = first_d;
  assign i1.last = last_d;
  assign i1.in_valid = in_valid_d;
  assign i1.out_ready = out_ready_d;

  mac_dot #(.OPSIZE(OPSIZE), .GUARD(GUARD), .OUTSIZE(OUTSIZE), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(i0.slave)
  );
  mac_dot #(.OPSIZE(OPSIZE), .GUARD(GUARD), .OUTSIZE(OUTSIZE), .SHIFT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(i1.slave)
  );

  typedef struct {
    longint out;
    bit     ovf;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint macc[2];
  bit     movf[2];
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unbounded integer math, explicit wrap at ACCW, shift, clamp.
  function automatic void model_term(input int a, input int b, input bit f, input bit l);
    longint p, s, sh;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      p = longint'(a) * longint'(b);
      if (f) begin
        macc[d] = p;
        movf[d] = 1'b0;
      end else begin
        s = macc[d] + p;
        if (s > ACC_MAX) begin
          s = s - (longint'(1) <<< ACCW);
          movf[d] = 1'b1;
        end else if (s < ACC_MIN) begin
          s = s + (longint'(1) <<< ACCW);
          movf[d] = 1'b1;
        end
        macc[d] = s;
      end
      if (l) begin
        sh = macc[d] >>> ((d == 0) ? 0 : 4);
        e.ovf = movf[d];
        if (sh > OUT_MAX) begin
          sh = OUT_MAX;
          e.ovf = 1'b1;
        end else if (sh < OUT_MIN) begin
          sh = OUT_MIN;
          e.ovf = 1'b1;
        end
        e.out = sh;
        movf[d] = e.ovf;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      macc[d] = 0;
      movf[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endfunction

  task automatic send(input int a, input int b, input bit f, input bit l);
    int k;
    @(negedge clk);
    a_d = OPSIZE'(a);
    b_d = OPSIZE'(b);
    first_d = f;
    last_d = l;
    in_valid_d = 1'b1;
    k = 0;
    while (!i0.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid_d = 1'b0;
    // Scramble the inputs while the term is in flight.
    a_d = OPSIZE'($urandom);
    b_d = OPSIZE'($urandom);
    first_d = 1'($urandom);
    last_d = 1'($urandom);
    model_term(a, b, f, l);
  endtask

  // Waits for the result after the last term, compares, optionally stalls.
  task automatic collect(input int hold);
    int k;
    exp_t e0, e1;
    @(negedge clk);
    k = 1;
    while (!i0.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!i0.out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    check("latency", k, OPSIZE + 2);
    check("out_valid_s4", i1.out_valid, 1);
    if (q0.size() == 0 || q1.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("out_s0", i0.OUT, e0.out);
    check("ovf_s0", i0.ovf, e0.ovf);
    check("out_s4", i1.OUT, e1.out);
    check("ovf_s4", i1.ovf, e1.ovf);
    for (int h = 0; h < hold; h++) begin
      in_valid_d = 1'b1;
      @(negedge clk);
      check("hold_out", i0.OUT, e0.out);
      check("hold_vld", i0.out_valid, 1);
      check("hold_in_rdy", i0.in_ready, 0);
    end
    in_valid_d = 1'b0;
    out_ready_d = 1'b1;
    @(posedge clk);
    #1;
    out_ready_d = 1'b0;
    @(negedge clk);
    check("released_vld", i0.out_valid, 0);
    check("released_in_rdy", i0.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out", i0.OUT, 0);
    check("rst_ovf", i0.ovf, 0);
    check("rst_vld", i0.out_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_rdy", i0.in_ready, 1);

    // Three-term dot product: 5280 - 5280 - 5280.
    send(48, 110, 1, 0);
    send(48, -110, 0, 0);
    send(-48, 110, 0, 1);
    collect(0);

    // Single-term products.
    send(-1, -1, 1, 1);     collect(0);
    send(-128, -128, 1, 1); collect(0);

    // Clamp both ways.
    send(127, 127, 1, 0);  send(127, 127, 0, 0);  send(127, 127, 0, 1);  collect(0);
    send(-128, 127, 1, 0); send(-128, 127, 0, 0); send(-128, 127, 0, 1); collect(0);

    // Shift rounding toward minus infinity on the SHIFT=4 instance.
    send(48, -110, 1, 1); collect(0);
    send(-1, 1, 1, 1);    collect(0);

    // Accumulator wrap: 40 x 16384 exceeds the 20-bit range.
    for (int i = 0; i < 40; i++) send(-128, -128, i == 0, i == 39);
    collect(0);

    // Result held under backpressure.
    send(5, 6, 1, 1);
    collect(5);

    // Reset mid-multiply discards the term.
    send(100, 100, 1, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld", i0.out_valid, 0);
    check("mid_rst_out", i0.OUT, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    send(3, 4, 1, 1);
    collect(0);

    // No first since reset: accumulates onto zero.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    send(20, 50, 0, 1);
    collect(0);

    // Random dot products.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 5);
      for (int t = 0; t < n; t++)
        send($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, t == 0, t == n - 1);
      collect($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot.md
MAC_DOT -- requirements
Module: mac_dot

Interface
REQ-001 The block SHALL have parameter OPSIZE, default 8: signed operand width in bits, minimum 2.
REQ-002 The block SHALL have parameter GUARD, default 4: accumulator guard bits; the accumulator width is ACCW = 2*OPSIZE+GUARD.
REQ-003 The block SHALL have parameter OUTSIZE, default 16: result width, range 2 to ACCW.
REQ-004 The block SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation, range 0 to ACCW-OUTSIZE.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 The block SHALL have port A and port B, each input, OPSIZE bits, two's-complement operands.
REQ-008 The block SHALL have port first, input, 1 bit: this term starts a new dot product.
REQ-009 The block SHALL have port last, input, 1 bit: this term ends the dot product.
REQ-010 The block SHALL have port in_valid (input, 1 bit) and port in_ready (output, 1 bit) forming the term handshake.
REQ-011 The block SHALL have port OUT, output, OUTSIZE bits, signed: saturated result.
REQ-012 The block SHALL have port ovf, output, 1 bit: set when saturation occurred, or when the accumulator wrapped, in this dot product.
REQ-013 The block SHALL have port out_valid (input out_ready, output out_valid, 1 bit each) forming the result handshake.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, ACC and HOLD, with IDLE as the reset state.
REQ-015 in_ready SHALL be 1 only in IDLE; a term is accepted on a rising edge with in_valid && in_ready, which latches A, B, first and last, starts the multiplier, and moves the FSM to MUL.
REQ-016 MUL SHALL last exactly OPSIZE cycles, producing the exact signed 2*OPSIZE-bit product; the FSM then moves to ACC.
REQ-017 ACC SHALL last 1 cycle: acc = product if first was latched, otherwise acc = acc + sign-extended product, both at ACCW bits.
REQ-018 On leaving ACC, the FSM SHALL move to HOLD if last was latched, otherwise to IDLE.
REQ-019 Per-term occupancy SHALL be OPSIZE+2 cycles from the accept edge to the next in_ready=1.
REQ-020 In HOLD, out_valid SHALL be 1 and OUT and ovf SHALL be stable until out_valid && out_ready, after which the FSM returns to IDLE on the same edge.
REQ-021 OUT SHALL equal acc >>> SHIFT (truncation toward minus infinity), clamped to [-2^(OUTSIZE-1), 2^(OUTSIZE-1)-1].
REQ-022 ovf SHALL be sticky within one dot product, set on clamp or on signed overflow of the ACCW-bit addition, and cleared when a term with first=1 is accepted.
REQ-023 A term with first=1 and last=1 SHALL be a single-term product.
REQ-024 A term accepted without any prior first since reset SHALL accumulate onto acc=0.
REQ-025 In IDLE, in HOLD, and during MUL/ACC, A and B changes SHALL be ignored except on the accept edge.
REQ-026 in_valid SHALL be ignored outside IDLE.

Reset
REQ-027 While reset_n=0, the block SHALL asynchronously force state=IDLE, acc=0, OUT=0, ovf=0, out_valid=0 and in_ready=1 as soon as reset_n=1 is seen.
REQ-028 Assertion of reset_n during MUL, ACC or HOLD SHALL abort the operation and discard the partial product and result.
REQ-029 Deassertion of reset_n SHALL be synchronised to clk by the integrating level; the block SHALL NOT accept terms on the first edge after release.

Structure
REQ-030 The FSM state enum and a saturate function taking (value, width) SHALL live in shared package iir_pkg, together with the filter coefficient typedefs.
REQ-031 The block SHALL use one sub-module, mul_seq: a parametrised signed iterative shift-add multiplier (start/done, latency OPSIZE cycles) instantiated once.
REQ-032 The accumulator, saturation and handshake logic SHALL remain in mac_dot.

Verification (OPSIZE=8, GUARD=4, OUTSIZE=16, SHIFT=0 unless stated)
REQ-033 Terms (48,110,first), (48,-110), (-48,110,last) SHALL produce OUT=-5280 and ovf=0, with out_valid 1 cycle after the third ACC.
REQ-034 A single term (-1,-1,first,last) SHALL produce OUT=1; a single term (-128,-128,first,last) SHALL produce OUT=16384.
REQ-035 Terms (127,127) x3 SHALL produce OUT=32767 and ovf=1; terms (-128,127) x3 SHALL produce OUT=-32768 and ovf=1.
REQ-036 With SHIFT=4, the single term (48,-110) SHALL produce OUT=-330 (i.e. -5280>>>4); the single term (-1,1) SHALL produce OUT=-1.
REQ-037 Holding out_ready=0 for 5 cycles in HOLD SHALL keep OUT and out_valid stable, with in_ready=0 throughout.
REQ-038 Pulsing reset_n low mid-MUL SHALL force out_valid=0 and OUT=0 immediately; a subsequent (3,4,first,last) term SHALL produce OUT=12.
REQ-039 A random-stimulus scoreboard SHALL check every result against a reference model.
